missile_scheduler: RTL

Controller that sequences a pool of up to `NUM_SLOTS` player missiles for the shooter game, replacing the single hard-wired missile with a scheduled pool. Once per frame it:
- decodes the fire key from the USB keycode;
- enforces a fire cooldown;
- allocates the lowest free slot and spawns it centred on the ship;
- advances every live missile upward and retires missiles at the top edge or on collision.

Its per-slot position and active outputs feed the colour mapper and the collision detector.

---
 rtl/missile_scheduler_pkg.sv | 20 ++
 rtl/missile_scheduler_if.sv | 27 ++
 rtl/missile_scheduler_slot.sv | 66 ++++++
 rtl/missile_scheduler.sv | 99 +++++++++
 4 files changed

// File: rtl/missile_scheduler_pkg.sv
// Shared missile definitions used by the scheduler, collision detector and colour mapper.
package missile_pkg;

  typedef enum logic {SLOT_IDLE, SLOT_FLY} slot_state_t;

  localparam int MISSILE_W = 4;
  localparam int MISSILE_H = 6;

  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_D = 8'h07;

  // Missile left X centred on the ship; clamps to 0 near the left edge.
  function automatic logic [9:0] spawn_x(input logic [9:0] ship_x, input logic [9:0] size_x);
    logic [9:0] centre;
    centre = ship_x + (size_x >> 1);
    return (centre < 10'd2) ? 10'd0 : centre - 10'd2;
  endfunction

endpackage

// File: rtl/missile_scheduler_if.sv
// Bus between the missile scheduler and the game logic (keyboard, ship, collision, video).
interface missile_scheduler_if #(
  parameter int NUM_SLOTS = 4
);
  logic [7:0]              keycode;
  logic [9:0]              ShipX;
  logic [9:0]              ShipY;
  logic [9:0]              Ship_sizeX;
  logic [NUM_SLOTS-1:0]    Collision;
  logic [NUM_SLOTS-1:0]    Active;
  logic [10*NUM_SLOTS-1:0] MissileX;
  logic [10*NUM_SLOTS-1:0] MissileY;
  logic [9:0]              MissileSX;
  logic [9:0]              MissileSY;
  logic                    FireAck;
  logic                    CoolBusy;

  modport master (
    output keycode, ShipX, ShipY, Ship_sizeX, Collision,
    input  Active, MissileX, MissileY, MissileSX, MissileSY, FireAck, CoolBusy
  );

  modport slave (
    input  keycode, ShipX, ShipY, Ship_sizeX, Collision,
    output Active, MissileX, MissileY, MissileSX, MissileSY, FireAck, CoolBusy
  );
endinterface

// File: rtl/missile_scheduler_slot.sv
// One missile slot: spawn on allocation, rise STEP pixels per frame, retire on hit or at the top.
//   state     | meaning
//   SLOT_IDLE | free; holds last X/Y, ignores collision
//   SLOT_FLY  | in flight; moves up each frame until hit or top edge
module missile_slot
  import missile_pkg::*;
#(
  parameter int STEP  = 4,
  parameter int Y_MIN = 0
) (
  input  logic       frame_clk,
  input  logic       Reset_n,
  input  logic       i_alloc,
  input  logic [9:0] i_spawn_x,
  input  logic [9:0] i_spawn_y,
  input  logic       i_collision,
  output logic       o_active,
  output logic [9:0] o_x,
  output logic [9:0] o_y
);

  localparam logic [10:0] RETIRE_LIM = 11'(Y_MIN + STEP);

  slot_state_t r_state;
  slot_state_t w_state_next;
  logic [9:0]  r_x;
  logic [9:0]  r_y;
  logic        w_retire;

  // Below this limit another step would cross Y_MIN, so the missile retires in place.
  assign w_retire = i_collision || ({1'b0, r_y} < RETIRE_LIM);

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= SLOT_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      SLOT_IDLE: if (i_alloc)  w_state_next = SLOT_FLY;
      SLOT_FLY:  if (w_retire) w_state_next = SLOT_IDLE;
      default:                 w_state_next = SLOT_IDLE;
    endcase
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_x <= '0;
      r_y <= '0;
    end else if (r_state == SLOT_IDLE && i_alloc) begin
      r_x <= i_spawn_x;
      r_y <= i_spawn_y;
    end else if (r_state == SLOT_FLY && !w_retire) begin
      r_y <= r_y - 10'(STEP);
    end
  end

  assign o_active = (r_state == SLOT_FLY);
  assign o_x      = r_x;
  assign o_y      = r_y;

endmodule

// File: rtl/missile_scheduler.sv
// Frame-rate missile pool scheduler: fire-key edge detect, cooldown, lowest-free allocation.
module missile_scheduler
  import missile_pkg::*;
#(
  parameter int         NUM_SLOTS = 4,
  parameter int         STEP      = 4,
  parameter int         COOLDOWN  = 8,
  parameter logic [7:0] FIRE_KEY  = KEY_W,
  parameter int         Y_MIN     = 0
) (
  input logic                frame_clk,
  input logic                Reset_n,
  missile_scheduler_if.slave bus
);

  localparam int            CW        = (COOLDOWN > 2) ? $clog2(COOLDOWN) : 1;
  localparam logic [CW-1:0] COOL_LOAD = (COOLDOWN > 0) ? CW'(COOLDOWN - 1) : '0;

  logic                    r_key_prev;
  logic                    r_fire_ack;
  logic [CW-1:0]           r_cool;

  logic                    w_key_hit;
  logic                    w_request;
  logic                    w_height_ok;
  logic                    w_any_free;
  logic                    w_accept;
  logic [NUM_SLOTS-1:0]    w_active;
  logic [NUM_SLOTS-1:0]    w_grant;
  logic [NUM_SLOTS-1:0]    w_alloc;
  logic [9:0]              w_spawn_x;
  logic [9:0]              w_spawn_y;
  logic [10*NUM_SLOTS-1:0] w_x;
  logic [10*NUM_SLOTS-1:0] w_y;

  assign w_key_hit   = (bus.keycode == FIRE_KEY);
  assign w_request   = w_key_hit && !r_key_prev;
  assign w_height_ok = (bus.ShipY >= 10'(MISSILE_H + Y_MIN));
  assign w_any_free  = ~&w_active;
  assign w_accept    = w_request && (r_cool == '0) && w_any_free && w_height_ok;

  assign w_spawn_x   = spawn_x(bus.ShipX, bus.Ship_sizeX);
  assign w_spawn_y   = bus.ShipY - 10'(MISSILE_H);

  // Scanning from the top down lets the lowest free slot overwrite any higher one.
  always_comb begin
    w_grant = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!w_active[i]) begin
        w_grant    = '0;
        w_grant[i] = 1'b1;
      end
    end
  end

  assign w_alloc = w_grant & {NUM_SLOTS{w_accept}};

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_key_prev <= 1'b0;
      r_fire_ack <= 1'b0;
      r_cool     <= '0;
    end else begin
      r_key_prev <= w_key_hit;
      r_fire_ack <= w_accept;
      if (w_accept) begin
        r_cool <= COOL_LOAD;
      end else if (r_cool != '0) begin
        r_cool <= r_cool - CW'(1);
      end
    end
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    missile_slot #(
      .STEP  (STEP),
      .Y_MIN (Y_MIN)
    ) u_slot (
      .frame_clk   (frame_clk),
      .Reset_n     (Reset_n),
      .i_alloc     (w_alloc[g]),
      .i_spawn_x   (w_spawn_x),
      .i_spawn_y   (w_spawn_y),
      .i_collision (bus.Collision[g]),
      .o_active    (w_active[g]),
      .o_x         (w_x[10*g +: 10]),
      .o_y         (w_y[10*g +: 10])
    );
  end

  assign bus.Active    = w_active;
  assign bus.MissileX  = w_x;
  assign bus.MissileY  = w_y;
  assign bus.MissileSX = 10'(MISSILE_W);
  assign bus.MissileSY = 10'(MISSILE_H);
  assign bus.FireAck   = r_fire_ack;
  assign bus.CoolBusy  = (r_cool != '0);

endmodule
